// File: rtl/io_display_ctrl_if.sv
// ---------------------------------------------------------------------------
// io_display_ctrl_if
//   Store bus from the core into the IO display controller.
//   ioWE      store strobe, at most one store per cycle
//   ioAddr    store byte address; bit 14 selects IO space, bits 5:1 the register
//   ioWrData  store data
// Modports: master drives the bus (core side), slave receives it (controller).
// ---------------------------------------------------------------------------
interface io_display_ctrl_if;
    logic        ioWE;
    logic [14:0] ioAddr;
    logic [15:0] ioWrData;

    modport master (output ioWE, output ioAddr, output ioWrData);
    modport slave  (input  ioWE, input  ioAddr, input  ioWrData);
endinterface

// File: rtl/io_display_ctrl.sv
// ---------------------------------------------------------------------------
// io_display_ctrl
//   Memory-mapped IO controller for the board display. Decodes IO stores into
//   the sort-status, lamp, LED-control and user-LED registers, snapshots the
//   cycle counter when the sort finishes, and time-multiplexes two 4-digit
//   7-segment displays through a shared scan scheduler.
// Ports:
//   clk         system clock
//   rst         asynchronous active-low reset
//   bus         store bus (slave modport): ioWE, ioAddr, ioWrData
//   cycle       free-running cycle counter
//   sortFinish  registered finish flag
//   lamp        lamp register
//   ddOut       segments {disp1[15:8], disp0[7:0]}, bits {dp,g,f,e,d,c,b,a}
//   ddGate      digit gates {disp1, disp0}, one-hot per display, active-high
// ---------------------------------------------------------------------------
module io_display_ctrl #(
    parameter logic [27:0] SCAN_COUNT = 28'h3000,   // clk cycles per digit slot, >= 2
    parameter int          DIGITS     = 4           // digits per display
) (
    input  logic                  clk,
    input  logic                  rst,
    io_display_ctrl_if.slave      bus,
    input  logic [31:0]           cycle,
    output logic                  sortFinish,
    output logic [7:0]            lamp,
    output logic [15:0]           ddOut,
    output logic [2*DIGITS-1:0]   ddGate
);

    localparam int DIG_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam logic [DIG_W-1:0] LAST_DIGIT = DIG_W'(DIGITS - 1);

    // Register map, indexed by ioAddr[5:1]
    localparam logic [4:0] REG_SORT_FINISH = 5'h00;
    localparam logic [4:0] REG_SORT_COUNT  = 5'h01;
    localparam logic [4:0] REG_LAMP        = 5'h02;
    localparam logic [4:0] REG_LED_CTRL    = 5'h03;
    localparam logic [4:0] REG_SORT_START  = 5'h10;

    // Hex digit to segment pattern, dp always off
    function automatic logic [7:0] hex7seg(input logic [3:0] n);
        logic [7:0] seg;
        case (n)
            4'h0: seg = 8'h3F;  4'h1: seg = 8'h06;  4'h2: seg = 8'h5B;  4'h3: seg = 8'h4F;
            4'h4: seg = 8'h66;  4'h5: seg = 8'h6D;  4'h6: seg = 8'h7D;  4'h7: seg = 8'h07;
            4'h8: seg = 8'h7F;  4'h9: seg = 8'h6F;  4'hA: seg = 8'h77;  4'hB: seg = 8'h7C;
            4'hC: seg = 8'h39;  4'hD: seg = 8'h5E;  4'hE: seg = 8'h79;  default: seg = 8'h71;
        endcase
        return seg;
    endfunction

    logic                sort_finish_q, sort_finish_d;
    logic [31:0]         cyc_snap_q,    cyc_snap_d;
    logic [15:0]         sort_count_q,  sort_count_d;
    logic [7:0]          lamp_q,        lamp_d;
    logic                mode_q,        mode_d;
    logic [3:0]          nib_q [8];
    logic [3:0]          nib_d [8];
    logic [27:0]         prescaler_q,   prescaler_d;
    logic [DIG_W-1:0]    digit_q,       digit_d;
    logic [15:0]         dd_out_q,      dd_out_d;
    logic [2*DIGITS-1:0] dd_gate_q,     dd_gate_d;

    logic             io_wr;
    logic [4:0]       reg_sel;
    logic [15:0]      word1, word0;
    logic [DIG_W+1:0] nib_shift;
    logic [DIGITS-1:0] gate_one;

    assign io_wr   = bus.ioWE && bus.ioAddr[14];
    assign reg_sel = bus.ioAddr[5:1];

    // NOTE: every signal gets its hold/default value before any branch, so no
    // path through this block leaves a variable unassigned and no latch is inferred.
    always_comb begin
        sort_finish_d = sort_finish_q;
        cyc_snap_d    = cyc_snap_q;
        sort_count_d  = sort_count_q;
        lamp_d        = lamp_q;
        mode_d        = mode_q;
        nib_d         = nib_q;
        prescaler_d   = prescaler_q + 28'd1;
        digit_d       = digit_q;

        // Snapshot follows the counter until the sort is flagged finished
        if (!sort_finish_q) begin
            cyc_snap_d = cycle;
        end

        if (io_wr) begin
            case (reg_sel)
                REG_SORT_FINISH: begin
                    sort_finish_d = 1'b1;
                    cyc_snap_d    = cycle;   // re-captures even when already frozen
                end
                REG_SORT_COUNT:  sort_count_d = bus.ioWrData;
                REG_LAMP:        lamp_d       = bus.ioWrData[7:0];
                REG_LED_CTRL:    mode_d       = bus.ioWrData[0];
                5'h08, 5'h09, 5'h0A, 5'h0B,
                5'h0C, 5'h0D, 5'h0E, 5'h0F:
                                 nib_d[reg_sel[2:0]] = bus.ioWrData[3:0];
                REG_SORT_START: begin
                    sort_finish_d = 1'b0;
                    sort_count_d  = 16'h0000;
                end
                default: ;                   // CE/CP/CH/CYCLE and unmapped: ignored
            endcase
        end

        // Scan scheduler: both displays share one digit index
        if (prescaler_q == SCAN_COUNT - 28'd1) begin
            prescaler_d = 28'd0;
            digit_d     = (digit_q == LAST_DIGIT) ? '0 : digit_q + DIG_W'(1);
        end

        // Digit 0 is the most-significant nibble of each 16-bit word
        word1     = mode_q ? {nib_q[7], nib_q[6], nib_q[5], nib_q[4]} : sort_count_q;
        word0     = mode_q ? {nib_q[3], nib_q[2], nib_q[1], nib_q[0]} : cyc_snap_q[15:0];
        nib_shift = {LAST_DIGIT - digit_q, 2'b00};
        dd_out_d  = {hex7seg(4'(word1 >> nib_shift)), hex7seg(4'(word0 >> nib_shift))};

        gate_one  = {{(DIGITS-1){1'b0}}, 1'b1} << (LAST_DIGIT - digit_q);
        dd_gate_d = {gate_one, gate_one};
    end

    // NOTE: state updates use non-blocking assignments so every flop samples
    // the pre-edge values and simulation matches the synthesized registers.
    // NOTE: the user-nibble array is reset too: it is a small register file
    // whose contents are visible on the display right after reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sort_finish_q <= 1'b0;
            cyc_snap_q    <= '0;
            sort_count_q  <= '0;
            lamp_q        <= '0;
            mode_q        <= 1'b0;
            for (int i = 0; i < 8; i++) begin
                nib_q[i] <= '0;
            end
            prescaler_q   <= '0;
            digit_q       <= '0;
            dd_out_q      <= '0;
            dd_gate_q     <= '0;
        end else begin
            sort_finish_q <= sort_finish_d;
            cyc_snap_q    <= cyc_snap_d;
            sort_count_q  <= sort_count_d;
            lamp_q        <= lamp_d;
            mode_q        <= mode_d;
            nib_q         <= nib_d;
            prescaler_q   <= prescaler_d;
            digit_q       <= digit_d;
            dd_out_q      <= dd_out_d;
            dd_gate_q     <= dd_gate_d;
        end
    end

    assign sortFinish = sort_finish_q;
    assign lamp       = lamp_q;
    assign ddOut      = dd_out_q;
    assign ddGate     = dd_gate_q;

    // Address bits outside the decode and the upper snapshot half are not displayed
    logic unused_bits;
    assign unused_bits = ^{bus.ioAddr[13:6], bus.ioAddr[0], cyc_snap_q[31:16]};

endmodule

// File: tb/tb_io_display_ctrl.sv
// ---------------------------------------------------------------------------
// tb_io_display_ctrl
//   Directed bench for io_display_ctrl with a short scan period (4 clocks per
//   digit). A table of stores with expected lamp/flag/segment values drives
//   most of the register checks; hand-written sequences cover the cycle
//   snapshot freeze/recapture and reset in the middle of a scan.
// ---------------------------------------------------------------------------
module tb_io_display_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] cycle = 32'h0;
    logic        sortFinish;
    logic [7:0]  lamp;
    logic [15:0] ddOut;
    logic [7:0]  ddGate;
    bit          cyc_run = 1'b0;

    int total = 0;
    int bad   = 0;

    io_display_ctrl_if bus ();

    io_display_ctrl #(.SCAN_COUNT(28'd4), .DIGITS(4)) dut (
        .clk        (clk),
        .rst        (rst),
        .bus        (bus),
        .cycle      (cycle),
        .sortFinish (sortFinish),
        .lamp       (lamp),
        .ddOut      (ddOut),
        .ddGate     (ddGate)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (cyc_run) cycle = cycle + 32'd1;
    end

    typedef struct {
        logic        we;
        logic [14:0] addr;
        logic [15:0] data;
        int          dig;
        logic [15:0] exp_dd;
        logic [7:0]  exp_lamp;
        logic        exp_fin;
    } vec_t;

    vec_t vecs[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [7:0] gate_of(input int d);
        logic [3:0] g;
        g = 4'b1000 >> d;
        return {g, g};
    endfunction

    // One store cycle; returns at the falling edge after the capturing edge
    task automatic store(input logic we, input logic [14:0] addr, input logic [15:0] data);
        @(negedge clk);
        bus.ioWE     = we;
        bus.ioAddr   = addr;
        bus.ioWrData = data;
        @(posedge clk);
        @(negedge clk);
        bus.ioWE     = 1'b0;
    endtask

    // Let register updates reach the output stage, then wait for digit d
    task automatic wait_digit(input int d, output bit ok);
        ok = 1'b0;
        repeat (2) @(negedge clk);
        for (int i = 0; i < 40; i++) begin
            if (ddGate === gate_of(d)) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
        if (!ok) begin
            total++;
            bad++;
            $display("FAIL wait_digit%0d: timed out, ddGate=%h", d, ddGate);
        end
    endtask

    initial begin
        bit ok;
        logic [7:0] snap_seg [4];
        logic [7:0] exp_gate;

        bus.ioWE     = 1'b0;
        bus.ioAddr   = '0;
        bus.ioWrData = '0;
        cycle        = 32'h0000_C0DE;

        // Reset state
        #2 rst = 1'b0;
        #1;
        check("reset_ddOut",  ddOut, 16'h0);
        check("reset_ddGate", ddGate, 8'h0);
        check("reset_lamp",   lamp, 8'h0);
        check("reset_fin",    sortFinish, 1'b0);
        @(negedge clk);
        rst = 1'b1;

        // we, addr, data, digit, ddOut, lamp, sortFinish
        vecs.push_back('{1'b1, 15'h4004, 16'h12A5, 0, 16'h3F39, 8'hA5, 1'b0}); // LAMP
        vecs.push_back('{1'b1, 15'h4002, 16'hBEEF, 0, 16'h7C39, 8'hA5, 1'b0}); // SORT_COUNT
        vecs.push_back('{1'b0, 15'h0000, 16'h0000, 1, 16'h793F, 8'hA5, 1'b0});
        vecs.push_back('{1'b0, 15'h0000, 16'h0000, 2, 16'h795E, 8'hA5, 1'b0});
        vecs.push_back('{1'b0, 15'h0000, 16'h0000, 3, 16'h7179, 8'hA5, 1'b0});
        vecs.push_back('{1'b1, 15'h0004, 16'h0077, 0, 16'h7C39, 8'hA5, 1'b0}); // not IO space
        vecs.push_back('{1'b1, 15'h4028, 16'hFFFF, 0, 16'h7C39, 8'hA5, 1'b0}); // CYCLE: ignored
        vecs.push_back('{1'b0, 15'h4004, 16'h00FF, 0, 16'h7C39, 8'hA5, 1'b0}); // no strobe
        vecs.push_back('{1'b1, 15'h4006, 16'h0001, 0, 16'h3F3F, 8'hA5, 1'b0}); // mode 1
        vecs.push_back('{1'b1, 15'h4010, 16'h0000, 3, 16'h3F3F, 8'hA5, 1'b0}); // LED0
        vecs.push_back('{1'b1, 15'h4012, 16'h0001, 2, 16'h3F06, 8'hA5, 1'b0}); // LED1
        vecs.push_back('{1'b1, 15'h4014, 16'h0002, 1, 16'h3F5B, 8'hA5, 1'b0}); // LED2
        vecs.push_back('{1'b1, 15'h4016, 16'h0003, 0, 16'h3F4F, 8'hA5, 1'b0}); // LED3
        vecs.push_back('{1'b1, 15'h4018, 16'h0004, 3, 16'h663F, 8'hA5, 1'b0}); // LED4
        vecs.push_back('{1'b1, 15'h401A, 16'h0005, 2, 16'h6D06, 8'hA5, 1'b0}); // LED5
        vecs.push_back('{1'b1, 15'h401C, 16'h0006, 1, 16'h7D5B, 8'hA5, 1'b0}); // LED6
        vecs.push_back('{1'b1, 15'h401E, 16'hFFF7, 0, 16'h074F, 8'hA5, 1'b0}); // LED7, upper bits dropped
        vecs.push_back('{1'b0, 15'h0000, 16'h0000, 1, 16'h7D5B, 8'hA5, 1'b0});
        vecs.push_back('{1'b0, 15'h0000, 16'h0000, 2, 16'h6D06, 8'hA5, 1'b0});
        vecs.push_back('{1'b0, 15'h0000, 16'h0000, 3, 16'h663F, 8'hA5, 1'b0});
        vecs.push_back('{1'b1, 15'h4006, 16'hFFFE, 0, 16'h7C39, 8'hA5, 1'b0}); // mode 0
        vecs.push_back('{1'b1, 15'h4020, 16'h1234, 0, 16'h3F39, 8'hA5, 1'b0}); // SORT_START
        vecs.push_back('{1'b1, 15'h4004, 16'h005A, 0, 16'h3F39, 8'h5A, 1'b0}); // LAMP

        for (int i = 0; i < vecs.size(); i++) begin
            store(vecs[i].we, vecs[i].addr, vecs[i].data);
            check($sformatf("vec%0d_lamp", i), lamp, vecs[i].exp_lamp);
            check($sformatf("vec%0d_fin", i), sortFinish, vecs[i].exp_fin);
            wait_digit(vecs[i].dig, ok);
            if (ok) check($sformatf("vec%0d_ddOut", i), ddOut, vecs[i].exp_dd);
        end

        // Sort finish: snapshot 0x12345 then freeze while cycle keeps running
        cycle = 32'h0001_2345;
        store(1'b1, 15'h4000, 16'h0000);
        cyc_run = 1'b1;
        check("finish_flag", sortFinish, 1'b1);
        snap_seg = '{8'h5B, 8'h4F, 8'h66, 8'h6D};
        for (int d = 0; d < 4; d++) begin
            wait_digit(d, ok);
            if (ok) check($sformatf("frozen_d%0d", d), ddOut, {8'h3F, snap_seg[d]});
        end
        // Repeated finish re-captures
        cyc_run = 1'b0;
        cycle   = 32'h0000_ABCD;
        store(1'b1, 15'h4000, 16'h0000);
        wait_digit(0, ok);
        if (ok) check("recapture_d0", ddOut, 16'h3F77);
        // Sort start: snapshot tracks cycle again
        cycle = 32'h0000_9876;
        store(1'b1, 15'h4020, 16'h0000);
        check("start_flag", sortFinish, 1'b0);
        wait_digit(0, ok);
        if (ok) check("track_d0", ddOut, 16'h3F6F);
        wait_digit(3, ok);
        if (ok) check("track_d3", ddOut, 16'h3F7D);

        // Mid-scan reset: user mode with visible nibble so a missed reset shows up
        store(1'b1, 15'h4006, 16'h0001);
        store(1'b1, 15'h401E, 16'h000F);
        cycle = 32'h0;
        wait_digit(2, ok);
        #1 rst = 1'b0;
        #1;
        check("midreset_ddOut",  ddOut, 16'h0);
        check("midreset_ddGate", ddGate, 8'h0);
        check("midreset_lamp",   lamp, 8'h0);
        check("midreset_fin",    sortFinish, 1'b0);
        @(negedge clk);
        rst = 1'b1;
        // Gate sequence 88,44,22,11,88 with four edges per digit
        for (int e = 1; e <= 17; e++) begin
            @(negedge clk);
            if (e <= 4)       exp_gate = 8'h88;
            else if (e <= 8)  exp_gate = 8'h44;
            else if (e <= 12) exp_gate = 8'h22;
            else if (e <= 16) exp_gate = 8'h11;
            else              exp_gate = 8'h88;
            check($sformatf("scan_e%0d", e), ddGate, exp_gate);
            if (e == 2) check("post_reset_ddOut", ddOut, 16'h3F3F);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
